// File: rtl/regfile_sb.sv
// Integer register file x0..x31 with one writeback port, same-cycle write-through
// bypass on both read ports, and a per-register load-pending scoreboard that stalls decode.
module regfile_sb #(
  parameter int XLEN          = 32,
  parameter int REG_NUM       = 32,
  parameter int REG_IDX_WIDTH = 5
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [REG_IDX_WIDTH-1:0] rs1_idx_i,
  input  logic                     rs1_en_i,
  input  logic [REG_IDX_WIDTH-1:0] rs2_idx_i,
  input  logic                     rs2_en_i,
  output logic [XLEN-1:0]          rs1_rdata_o,
  output logic [XLEN-1:0]          rs2_rdata_o,
  input  logic                     wb_rd_en_i,
  input  logic [REG_IDX_WIDTH-1:0] wb_rd_idx_i,
  input  logic [XLEN-1:0]          wb_rd_wdata_i,
  input  logic                     ld_issue_en_i,
  input  logic [REG_IDX_WIDTH-1:0] ld_issue_idx_i,
  output logic                     ld_stall_o
);

  // Entry 0 is never written and busy[0] is never set, so x0 stays hard-wired to zero.
  logic [XLEN-1:0]    regs [REG_NUM];
  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic               wb_write;
  logic               wb_hit1;
  logic               wb_hit2;

  assign wb_write = wb_rd_en_i && (wb_rd_idx_i != '0);
  assign wb_hit1  = wb_rd_en_i && (wb_rd_idx_i == rs1_idx_i) && (rs1_idx_i != '0);
  assign wb_hit2  = wb_rd_en_i && (wb_rd_idx_i == rs2_idx_i) && (rs2_idx_i != '0);

  // Set is applied after clear so a load issuing to the register being written back keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_write) begin
      busy_nxt[wb_rd_idx_i] = 1'b0;
    end
    if (ld_issue_en_i && (ld_issue_idx_i != '0)) begin
      busy_nxt[ld_issue_idx_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wb_write) begin
        regs[wb_rd_idx_i] <= wb_rd_wdata_i;
      end
      busy <= busy_nxt;
    end
  end

  always_comb begin
    rs1_rdata_o = '0;
    if (rs1_en_i && (rs1_idx_i != '0)) begin
      rs1_rdata_o = wb_hit1 ? wb_rd_wdata_i : regs[rs1_idx_i];
    end
  end

  always_comb begin
    rs2_rdata_o = '0;
    if (rs2_en_i && (rs2_idx_i != '0)) begin
      rs2_rdata_o = wb_hit2 ? wb_rd_wdata_i : regs[rs2_idx_i];
    end
  end

  // A register being written back this cycle is served by the bypass rather than stalled.
  assign ld_stall_o = (rs1_en_i && busy[rs1_idx_i] && !wb_hit1) ||
                      (rs2_en_i && busy[rs2_idx_i] && !wb_hit2);

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Integer register file (x0..x31) that answers the decode stage's rs1/rs2 read requests.
- Takes the single writeback write port.
- Holds a per-register load-pending scoreboard and raises a stall when decode reads a register whose load has not yet written back.
- Sits between the decode stage (read side) and the writeback stage (write side); the load-issue strobe comes from EX.

Parameters:
XLEN, 32, data width of every register
REG_NUM, 32, number of architectural registers (x0 included)
REG_IDX_WIDTH, 5, register index width (log2 REG_NUM)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  reset; one clock, asynchronous, active-low
rs1_idx_i  input  REG_IDX_WIDTH  decode read index, port 1
rs1_en_i  input  1  decode actually reads rs1
rs2_idx_i  input  REG_IDX_WIDTH  decode read index, port 2
rs2_en_i  input  1  decode actually reads rs2
rs1_rdata_o  output  XLEN  read data, port 1
rs2_rdata_o  output  XLEN  read data, port 2
wb_rd_en_i  input  1  writeback write enable
wb_rd_idx_i  input  REG_IDX_WIDTH  writeback destination
wb_rd_wdata_i  input  XLEN  writeback data
ld_issue_en_i  input  1  a load with rd_en leaves EX this cycle
ld_issue_idx_i  input  REG_IDX_WIDTH  that load's rd
ld_stall_o  output  1  decode must hold; read operand still pending

Behaviour:
- Reset (rst_n_i low, asynchronous): registers x1..x31 = 0; all busy bits = 0. Outputs are combinational from reset state: rdata = 0, ld_stall_o = 0.
- x0: always reads 0; writes to x0 dropped; busy bit for x0 never set.
- Write: on rising edge, if wb_rd_en_i and wb_rd_idx_i != 0, then reg[wb_rd_idx_i] <= wb_rd_wdata_i.
- Read is combinational, zero latency. rsN_rdata_o equals, in priority order:
  - 0 if rsN_en_i = 0 or rsN_idx_i = 0;
  - else wb_rd_wdata_i if wb_rd_en_i and wb_rd_idx_i == rsN_idx_i (write-through bypass, same cycle);
  - else reg[rsN_idx_i].
- Scoreboard: busy[REG_NUM-1:1], one bit per register.
  - Set on edge when ld_issue_en_i and ld_issue_idx_i != 0.
  - Cleared on edge when wb_rd_en_i and wb_rd_idx_i matches.
  - Same index set and cleared in one cycle: set wins (newer load owns the register).
  - Different indices in one cycle: both actions apply.
- Stall (combinational):
  - ld_stall_o = (rs1_en_i & busy[rs1] & !wb_hit1) | (rs2_en_i & busy[rs2] & !wb_hit2).
  - wb_hitN = wb_rd_en_i & (wb_rd_idx_i == rsN_idx_i) & rsN_idx_i != 0.
  - A register whose load writes back this cycle is served by bypass, not stalled.
  - ld_issue_en_i in the current cycle does not affect ld_stall_o until the next cycle; the EX-to-decode hazard that cycle is handled by the pipeline's existing load-use detection.
- Multiple loads to the same rd in flight: a single busy bit. The first writeback clears it; later loads are in-order, so the last writer wins in data.
- Reset asserted mid-operation: all state cleared immediately; pending loads forgotten.

Test Plan:
- Reset, then read x5 with rs1_en=1 -> rs1_rdata_o=0, ld_stall_o=0.
- Write x5=0xDEADBEEF (wb_rd_en=1), next cycle read rs1=x5, rs2=x5 -> both 0xDEADBEEF. Read with rs2_en=0 -> rs2_rdata_o=0.
- Write x0=0x1234, then read x0 -> 0. ld_issue_idx=0 then read x0 -> no stall.
- Same-cycle bypass: wb write x7=0x55AA while rs1=x7 -> rs1_rdata_o=0x55AA in that cycle; committed value read 0x55AA next cycle.
- Scoreboard: ld_issue x9 at cycle N.
  - Cycle N+1, rs2=x9, rs2_en=1 -> ld_stall_o=1.
  - Cycle N+2 wb x9=0x77 -> stall=0, rs2_rdata_o=0x77.
  - Cycle N+3 -> stall=0.
- Set/clear collision: wb x3 and ld_issue x3 in the same cycle -> next cycle read x3 stalls. Assert rst_n_i low while x3 busy -> stall drops immediately; all regs read 0.
